// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared async-FIFO helpers. Holds the pointer-width and depth
//                derivations and the Gray <-> binary conversion functions used
//                by both pointer domains.
//  Revision    : 1.0  initial release
// ============================================================================
package fifo_pkg;

    // Widest pointer the helper functions handle. Narrower pointers are
    // zero-extended on the way in and truncated on the way out.
    localparam int C_MAXW = 32;

    // Pointer width: one extra MSB beyond the RAM address, to tell full from empty.
    function automatic int ptrw_of(input int addrsize);
        return addrsize + 1;
    endfunction

    // Number of RAM entries for a given address width.
    function automatic int depth_of(input int addrsize);
        return 1 << addrsize;
    endfunction

    // Reflected binary code. Zero upper bits stay zero, so this works at any width.
    function automatic logic [C_MAXW-1:0] bin2gray(input logic [C_MAXW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down. Zero-extended inputs convert correctly.
    function automatic logic [C_MAXW-1:0] gray2bin(input logic [C_MAXW-1:0] g);
        logic [C_MAXW-1:0] b;
        b[C_MAXW-1] = g[C_MAXW-1];
        for (int i = C_MAXW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/gray2bin_conv.sv
`default_nettype none
// ============================================================================
//  Module      : gray2bin_conv
//  Description : Combinational Gray-to-binary converter of parameterised
//                width. Each binary bit is the XOR of all Gray bits at or
//                above its position.
//  Revision    : 1.0  initial release
// ============================================================================
module gray2bin_conv #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    // Each bit is a reduction over a slice rather than a chain through
    // bin_o, so no output bit feeds back into another.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin_o[i] = ^gray_i[WIDTH-1:i];
    end

endmodule : gray2bin_conv
`default_nettype wire

// File: rtl/wptr_full_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : wptr_full_ctrl
//  Description : Write-domain pointer and flag controller for the async FIFO.
//                Keeps binary and Gray write pointers, produces full,
//                programmable almost-full, fill level and a sticky overflow
//                flag from the synchronised Gray read pointer.
//  Options     : WPTR_FULL_DROP_CNT_EN - when defined, wdrop_cnt counts
//                dropped writes (saturating 16-bit); otherwise it is tied 0.
//  Revision    : 1.0  initial release
// ============================================================================
module wptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE     = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic                wovf_clr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                woverflow,
    output logic [15:0]         wdrop_cnt
);

    localparam int              PTRW    = ptrw_of(ADDRSIZE);
    localparam logic [PTRW-1:0] C_AFULL = PTRW'(AFULL_THRESH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTRW-1:0] wbin_q,   wbin_d;
    logic [PTRW-1:0] wptr_q,   wptr_d;
    logic            wfull_q,  wfull_d;
    logic            wafull_q, wafull_d;
    logic [PTRW-1:0] wlevel_q, wlevel_d;
    logic            wovf_q,   wovf_d;

    // ------------------------------------------------------------------
    // Combinational next-state terms
    // ------------------------------------------------------------------
    logic            w_accept;      // write actually taken this cycle
    logic            w_drop;        // write attempted while full
    logic [PTRW-1:0] w_rbin_sync;   // read pointer in binary
    logic [PTRW-1:0] w_full_gray;   // Gray value the write pointer has when full

    // Read pointer arrives in Gray through the 2-FF synchroniser; convert
    // once here so the fill computation is plain binary subtraction.
    gray2bin_conv #(
        .WIDTH (PTRW)
    ) u_rptr_g2b (
        .gray_i (wq2_rptr),
        .bin_o  (w_rbin_sync)
    );

    // Full means the write pointer is exactly one lap ahead: the top two
    // Gray bits are inverted relative to the read pointer, the rest match.
    assign w_full_gray = {~wq2_rptr[PTRW-1:PTRW-2], wq2_rptr[PTRW-3:0]};

    assign w_accept = winc & ~wfull_q;
    assign w_drop   = winc &  wfull_q;

    // Next pointer, flags and level, all derived from the post-write pointer
    // so an accepted write is reflected on the same edge it is taken.
    always_comb begin
        logic [PTRW-1:0] fill_next;
        wbin_d    = wbin_q + PTRW'(w_accept);
        wptr_d    = PTRW'(bin2gray(C_MAXW'(wbin_d)));
        fill_next = wbin_d - w_rbin_sync;
        wfull_d   = (wptr_d == w_full_gray);
        wafull_d  = (fill_next >= C_AFULL);
        wlevel_d  = fill_next;
    end

    // Sticky overflow: a dropped write sets it and beats a same-cycle clear.
    always_comb begin
        wovf_d = wovf_q;
        if (w_drop) begin
            wovf_d = 1'b1;
        end else if (wovf_clr) begin
            wovf_d = 1'b0;
        end
    end

    // Pointer and flag registers; reset asserts asynchronously.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
            wlevel_q <= '0;
            wovf_q   <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wptr_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
            wlevel_q <= wlevel_d;
            wovf_q   <= wovf_d;
        end
    end

`ifdef WPTR_FULL_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Dropped-write counter: saturates at all-ones; a drop in the same cycle
    // as a clear restarts the count at one rather than zero.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (w_drop) begin
            if (wovf_clr) begin
                drop_cnt_d = 16'd1;
            end else if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end else if (wovf_clr) begin
            drop_cnt_d = 16'd0;
        end
    end

    // Counter register.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            drop_cnt_q <= 16'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign wdrop_cnt = drop_cnt_q;
`else
    assign wdrop_cnt = 16'h0000;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign waddr        = wbin_q[PTRW-2:0];
    assign wptr         = wptr_q;
    assign wfull        = wfull_q;
    assign walmost_full = wafull_q;
    assign wlevel       = wlevel_q;
    assign woverflow    = wovf_q;

endmodule : wptr_full_ctrl
`default_nettype wire

// File: tb/tb_wptr_full_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wptr_full_ctrl
//  Description : Self-checking bench for wptr_full_ctrl (ADDRSIZE=4,
//                AFULL_THRESH=12). A counting model of writes and reads
//                supplies every expected value. Honours WPTR_FULL_DROP_CNT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wptr_full_ctrl;

    localparam int ASZ   = 4;
    localparam int DEPTH = 16;
    localparam int THR   = 12;

    logic           wclk = 1'b0;
    logic           wrst_n;
    logic           winc;
    logic [ASZ:0]   wq2_rptr;
    logic           wovf_clr;
    logic [ASZ-1:0] waddr;
    logic [ASZ:0]   wptr;
    logic           wfull;
    logic           walmost_full;
    logic [ASZ:0]   wlevel;
    logic           woverflow;
    logic [15:0]    wdrop_cnt;

    wptr_full_ctrl #(
        .ADDRSIZE     (ASZ),
        .AFULL_THRESH (THR)
    ) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .winc         (winc),
        .wq2_rptr     (wq2_rptr),
        .wovf_clr     (wovf_clr),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .woverflow    (woverflow),
        .wdrop_cnt    (wdrop_cnt)
    );

    always #5 wclk = ~wclk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: total accepted writes and total reads made visible.
    int m_wr, m_rd;
    bit m_full, m_ovf;
    int m_drop;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] gray5(input int b);
        logic [4:0] v;
        v = b[4:0];
        return v ^ (v >> 1);
    endfunction

    function automatic logic [15:0] exp_drop();
`ifdef WPTR_FULL_DROP_CNT_EN
        return 16'(m_drop);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic model_reset();
        m_wr = 0; m_rd = 0; m_full = 0; m_ovf = 0; m_drop = 0;
    endtask

    task automatic compare_all(input string tag);
        int fill;
        fill = m_wr - m_rd;
        check({tag, ".wptr"},   32'(wptr),         32'(gray5(m_wr)));
        check({tag, ".waddr"},  32'(waddr),        32'(m_wr % DEPTH));
        check({tag, ".wfull"},  32'(wfull),        32'(fill == DEPTH));
        check({tag, ".wafull"}, 32'(walmost_full), 32'(fill >= THR));
        check({tag, ".wlevel"}, 32'(wlevel),       32'(fill));
        check({tag, ".wovf"},   32'(woverflow),    32'(m_ovf));
        check({tag, ".wdrop"},  32'(wdrop_cnt),    32'(exp_drop()));
    endtask

    // One write-clock cycle: drive inputs, advance model, compare.
    task automatic step(input string tag, input logic inc, input logic clr, input int rd);
        bit dropped;
        @(negedge wclk);
        winc     = inc;
        wovf_clr = clr;
        wq2_rptr = gray5(rd);
        @(posedge wclk);
        #1;
        dropped = inc && m_full;
        if (inc && !m_full) m_wr++;
        m_rd   = rd;
        m_full = ((m_wr - m_rd) == DEPTH);
        if (dropped)  m_ovf = 1;
        else if (clr) m_ovf = 0;
        if (dropped)  m_drop = clr ? 1 : ((m_drop < 65535) ? m_drop + 1 : 65535);
        else if (clr) m_drop = 0;
        compare_all(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wrst_n = 1'b0; winc = 1'b0; wovf_clr = 1'b0; wq2_rptr = '0;
        model_reset();
        repeat (2) @(posedge wclk);
        #1;
        compare_all("reset");
        @(negedge wclk);
        wrst_n = 1'b1;

        // Burst interrupted by reset between edges.
        for (int i = 0; i < 5; i++) step("burst", 1'b1, 1'b0, 0);
        @(negedge wclk);
        #2 wrst_n = 1'b0;
        #1;
        model_reset();
        compare_all("rst_async");
        @(negedge wclk);
        winc   = 1'b0;
        wrst_n = 1'b1;
        step("post_rst", 1'b0, 1'b0, 0);
        check("post_rst.wptr0", 32'(wptr), 32'h0);

        // Fill to the almost-full threshold, then to full.
        for (int i = 0; i < 12; i++) step("fill", 1'b1, 1'b0, 0);
        check("fill12.afull", 32'(walmost_full), 32'h1);
        check("fill12.level", 32'(wlevel), 32'd12);
        for (int i = 0; i < 4; i++) step("fill", 1'b1, 1'b0, 0);
        check("fill16.full",  32'(wfull),  32'h1);
        check("fill16.level", 32'(wlevel), 32'd16);
        check("fill16.wptr",  32'(wptr),   32'b11000);

        // Writes while full are dropped.
        for (int i = 0; i < 3; i++) step("ovf", 1'b1, 1'b0, 0);
        check("ovf.wptr", 32'(wptr), 32'b11000);
        check("ovf.flag", 32'(woverflow), 32'h1);
`ifdef WPTR_FULL_DROP_CNT_EN
        check("ovf.drop", 32'(wdrop_cnt), 32'd3);
`else
        check("ovf.drop", 32'(wdrop_cnt), 32'd0);
`endif

        // Set beats clear; clear alone clears.
        step("race", 1'b1, 1'b1, 0);
        check("race.flag", 32'(woverflow), 32'h1);
        step("clr", 1'b0, 1'b1, 0);
        check("clr.flag", 32'(woverflow), 32'h0);

        // Drain: read pointer catches up.
        step("drain", 1'b0, 1'b0, 16);
        check("drain.full",  32'(wfull),        32'h0);
        check("drain.afull", 32'(walmost_full), 32'h0);
        check("drain.level", 32'(wlevel),       32'd0);

        // Wrap: reads trail writes by a constant 5 across pointer wrap.
        for (int i = 0; i < 5; i++) step("lead", 1'b1, 1'b0, 16);
        for (int i = 0; i < 40; i++) begin
            step("wrap", 1'b1, 1'b0, m_wr - 4);
            check("wrap.level5", 32'(wlevel), 32'd5);
            check("wrap.nofull", 32'(wfull),  32'h0);
        end

        // Randomised traffic: write-heavy then read-heavy phases.
        for (int i = 0; i < 400; i++) begin
            int  rd;
            bit  inc, clr;
            bit  wr_heavy;
            wr_heavy = ((i / 100) % 2) == 0;
            inc = $urandom_range(0, 99) < (wr_heavy ? 85 : 30);
            clr = $urandom_range(0, 99) < 8;
            rd  = m_rd;
            if ($urandom_range(0, 99) < (wr_heavy ? 20 : 70))
                rd = m_rd + int'($urandom_range(0, m_wr - m_rd));
            step("rand", inc, clr, rd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_wptr_full_ctrl
`default_nettype wire
